// File: rtl/seven_seg_if.sv
// Host-side bundle for the seven-segment scanner: digit data/controls in, pin drive out.
interface seven_seg_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_mask;
  logic                load;
  logic                enable;
  logic                lz_suppress;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  modport master (
    output value, dp_mask, load, enable, lz_suppress,
    input  seg, an, frame_tick
  );

  modport slave (
    input  value, dp_mask, load, enable, lz_suppress,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment driver: tear-free frame-boundary commit, per-slot blanking,
// optional leading-zero suppression; all pin outputs are registered.
module seven_seg_scanner #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  seven_seg_if.slave bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_scanner: DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seven_seg_scanner: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("seven_seg_scanner: BLANK_CYCLES must be < REFRESH_DIV");
  end

  // Team digit decoder: {a,b,c,d,e,f,g,dp}, dp left clear; non-BCD codes go dark.
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hFC;
      4'd1:    decode = 8'h60;
      4'd2:    decode = 8'hDA;
      4'd3:    decode = 8'hF2;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'hB6;
      4'd6:    decode = 8'hBE;
      4'd7:    decode = 8'hE0;
      4'd8:    decode = 8'hFE;
      4'd9:    decode = 8'hE6;
      default: decode = 8'h00;
    endcase
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] an_d;
  logic              tick_d;

  logic              slot_end_c;
  logic              last_digit_c;
  logic              commit_c;
  logic              blank_c;
  logic [3:0]        digit_c;
  logic [DIGITS-1:0] lead_zero_c;

  assign slot_end_c   = (cnt_q == CW'(REFRESH_DIV - 1));
  assign last_digit_c = (idx_q == IW'(DIGITS - 1));
  assign commit_c     = slot_end_c && last_digit_c;
  assign blank_c      = (32'(cnt_q) < BLANK_CYCLES);
  assign digit_c      = disp_val_q[4*idx_q +: 4];

  // Digit i is a leading zero when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    lead_zero_c = '0;
    for (int i = 1; i < int'(DIGITS); i++) begin
      lead_zero_c[i] = ((disp_val_q >> (4 * i)) == '0);
    end
  end

  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    seg_d      = 8'h00;
    an_d       = '1;
    tick_d     = 1'b0;

    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = last_digit_c ? '0 : idx_q + IW'(1);
    end

    // Commit reads the pending value from before this edge, so a colliding load waits a frame.
    if (commit_c) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      tick_d     = 1'b1;
    end

    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_mask;
    end

    if (bus.enable && !blank_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = (bus.lz_suppress && lead_zero_c[idx_q]) ? 8'h00 : decode(digit_c);
      seg_d[0] = seg_d[0] | disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      pend_val_q     <= '0;
      pend_dp_q      <= '0;
      disp_val_q     <= '0;
      disp_dp_q      <= '0;
      bus.seg        <= 8'h00;
      bus.an         <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pend_val_q     <= pend_val_d;
      pend_dp_q      <= pend_dp_d;
      disp_val_q     <= disp_val_d;
      disp_dp_q      <= disp_dp_d;
      bus.seg        <= seg_d;
      bus.an         <= an_d;
      bus.frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame/slot arithmetic model of the display.
module tb_seven_seg_scanner;

  localparam int DG = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = DG * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seven_seg_if #(.DIGITS(DG)) bus ();

  seven_seg_scanner #(
    .DIGITS(DG), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] dec [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hE6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int nchk = 0;
  int nerr = 0;

  // Model state: t = edges since reset release (= counter value ahead of the next edge).
  int          t = 0;
  logic [15:0] m_pv = '0, m_dv = '0;
  logic [3:0]  m_pd = '0, m_dd = '0;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_tick;
  int          e_c = -1, e_s = -1;
  logic [7:0]  cap [DG];
  int          cap_bad;

  task automatic tick();
    int c, s;
    logic [3:0] dig;
    @(posedge clk);
    if (rst) begin
      t = 0; m_pv = '0; m_pd = '0; m_dv = '0; m_dd = '0;
      e_seg = 8'h00; e_an = 4'hF; e_tick = 1'b0; e_c = -1; e_s = -1;
    end else begin
      c = t % RD;
      s = (t / RD) % DG;
      e_c = c; e_s = s;
      e_seg = 8'h00; e_an = 4'hF;
      if (bus.enable && c >= BL) begin
        e_an = ~(4'b0001 << s);
        dig  = 4'((m_dv >> (4 * s)) & 16'hF);
        if (bus.lz_suppress && s != 0 && (m_dv >> (4 * s)) == 16'h0) e_seg = 8'h00;
        else e_seg = dec[dig];
        e_seg[0] = e_seg[0] | m_dd[s];
      end
      e_tick = (c == RD - 1) && (s == DG - 1);
      if (e_tick) begin m_dv = m_pv; m_dd = m_pd; end
      if (bus.load) begin m_pv = bus.value; m_pd = bus.dp_mask; end
      t++;
    end
    #1;
  endtask

  task automatic to_frame_start();
    do tick(); while (!e_tick);
  endtask

  // Observe one full frame, recording each digit's segments and any model disagreement.
  task automatic capture_frame();
    cap_bad = 0;
    for (int k = 0; k < FR; k++) begin
      tick();
      if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_tick !== e_tick) cap_bad++;
      if (e_c == RD - 1) cap[e_s] = bus.seg;
    end
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] dp);
    bus.value = v; bus.dp_mask = dp; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1;
    tick(); tick();
    nchk++;
    if (bus.seg !== 8'h00 || bus.an !== 4'hF || bus.frame_tick !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: seg=%h an=%b tick=%b, want 00 1111 0", bus.seg, bus.an, bus.frame_tick);
    end
    rst = 1'b0;
    ticks = 0;
    for (int e = 1; e <= 2 * FR; e++) begin
      tick();
      nchk++;
      if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_tick !== e_tick) begin
        nerr++;
        $display("FAIL reset_model e=%0d: seg=%h an=%b tick=%b, want %h %b %b",
                 e, bus.seg, bus.an, bus.frame_tick, e_seg, e_an, e_tick);
      end
      if (e == 2) begin
        nchk++;
        if (bus.an !== 4'b1111 || bus.seg !== 8'h00) begin
          nerr++; $display("FAIL edge2_blank: an=%b seg=%h, want 1111 00", bus.an, bus.seg);
        end
      end
      if (e == 3) begin
        nchk++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'hFC) begin
          nerr++; $display("FAIL edge3_digit0: an=%b seg=%h, want 1110 fc", bus.an, bus.seg);
        end
      end
      if (e == 9) begin
        nchk++;
        if (bus.an !== 4'b1111) begin
          nerr++; $display("FAIL edge9_blank: an=%b, want 1111", bus.an);
        end
      end
      if (e == 11) begin
        nchk++;
        if (bus.an !== 4'b1101) begin
          nerr++; $display("FAIL edge11_digit1: an=%b, want 1101", bus.an);
        end
      end
      if (bus.frame_tick) ticks++;
    end
    nchk++;
    if (ticks !== 2) begin
      nerr++; $display("FAIL frame_tick_rate: got %0d pulses in 64 cycles, want 2", ticks);
    end
  endtask

  task automatic test_load_midframe();
    logic bad_early;
    repeat ($urandom_range(3, 20)) tick();
    load_value(16'h1234, 4'b0000);
    bad_early = 1'b0;
    while (!e_tick) begin
      tick();
      nchk++;
      if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_tick !== e_tick) begin
        nerr++;
        $display("FAIL midframe_model t=%0d: seg=%h an=%b, want %h %b", t, bus.seg, bus.an, e_seg, e_an);
      end
      if (bus.an !== 4'hF && bus.seg !== 8'hFC) bad_early = 1'b1;
    end
    nchk++;
    if (bad_early) begin nerr++; $display("FAIL midframe_no_tear: display changed before frame_tick, want 0000"); end
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[0] !== 8'h66 || cap[1] !== 8'hF2 || cap[2] !== 8'hDA || cap[3] !== 8'h60) begin
      nerr++;
      $display("FAIL load_1234: digits3..0=%h %h %h %h model_misses=%0d, want 60 da f2 66 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
  endtask

  task automatic test_back_to_back();
    while (t % FR != FR - 1) tick();
    load_value(16'h5678, 4'b0000);
    nchk++;
    if (bus.frame_tick !== 1'b1) begin
      nerr++; $display("FAIL collision_tick: frame_tick=%b, want 1", bus.frame_tick);
    end
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[0] !== 8'h66 || cap[1] !== 8'hF2 || cap[2] !== 8'hDA || cap[3] !== 8'h60) begin
      nerr++;
      $display("FAIL collision_old: digits3..0=%h %h %h %h misses=%0d, want 60 da f2 66 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[0] !== 8'hFE || cap[1] !== 8'hE0 || cap[2] !== 8'hBE || cap[3] !== 8'hB6) begin
      nerr++;
      $display("FAIL collision_new: digits3..0=%h %h %h %h misses=%0d, want b6 be e0 fe 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
  endtask

  task automatic test_lz_suppress();
    bus.lz_suppress = 1'b1;
    load_value(16'h0070, 4'b0100);
    to_frame_start();
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[3] !== 8'h00 || cap[2] !== 8'h01 || cap[1] !== 8'hE0 || cap[0] !== 8'hFC) begin
      nerr++;
      $display("FAIL lz_on: digits3..0=%h %h %h %h misses=%0d, want 00 01 e0 fc 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
    bus.lz_suppress = 1'b0;
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[3] !== 8'hFC || cap[2] !== 8'hFD || cap[1] !== 8'hE0 || cap[0] !== 8'hFC) begin
      nerr++;
      $display("FAIL lz_off: digits3..0=%h %h %h %h misses=%0d, want fc fd e0 fc 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
  endtask

  task automatic test_nonbcd();
    load_value(16'hA0F9, 4'b0000);
    to_frame_start();
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[3] !== 8'h00 || cap[2] !== 8'hFC || cap[1] !== 8'h00 || cap[0] !== 8'hE6) begin
      nerr++;
      $display("FAIL nonbcd: digits3..0=%h %h %h %h misses=%0d, want 00 fc 00 e6 0",
               cap[3], cap[2], cap[1], cap[0], cap_bad);
    end
    bus.lz_suppress = 1'b1;
    capture_frame();
    nchk++;
    if (cap_bad != 0 || cap[2] !== 8'hFC || cap[3] !== 8'h00) begin
      nerr++;
      $display("FAIL nonbcd_lz: digit3=%h digit2=%h misses=%0d, want 00 fc 0", cap[3], cap[2], cap_bad);
    end
    bus.lz_suppress = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.value = 16'($urandom); bus.dp_mask = 4'($urandom); bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) bus.lz_suppress = ~bus.lz_suppress;
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
      tick();
      nchk++;
      if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_tick !== e_tick) begin
        nerr++;
        $display("FAIL random t=%0d: seg=%h an=%b tick=%b, want %h %b %b",
                 t, bus.seg, bus.an, bus.frame_tick, e_seg, e_an, e_tick);
      end
    end
    bus.load = 1'b0; bus.enable = 1'b1; bus.lz_suppress = 1'b0;
  endtask

  task automatic test_enable_reset();
    int got_ticks, want_ticks;
    load_value(16'h4321, 4'b1111);
    to_frame_start();
    bus.enable = 1'b0;
    got_ticks = 0; want_ticks = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      nchk++;
      if (bus.an !== 4'hF || bus.seg !== 8'h00 || bus.frame_tick !== e_tick) begin
        nerr++;
        $display("FAIL disabled k=%0d: an=%b seg=%h tick=%b, want 1111 00 %b", k, bus.an, bus.seg, bus.frame_tick, e_tick);
      end
      if (bus.frame_tick) got_ticks++;
      if (e_tick) want_ticks++;
    end
    nchk++;
    if (got_ticks !== want_ticks || want_ticks == 0) begin
      nerr++; $display("FAIL disabled_ticks: got %0d, want %0d (nonzero)", got_ticks, want_ticks);
    end
    bus.enable = 1'b1;
    while (t % RD != 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchk++;
    if (bus.seg !== 8'h00 || bus.an !== 4'hF || bus.frame_tick !== 1'b0) begin
      nerr++; $display("FAIL midslot_reset: seg=%h an=%b tick=%b, want 00 1111 0", bus.seg, bus.an, bus.frame_tick);
    end
    for (int e = 1; e <= 3 * FR; e++) begin
      tick();
      nchk++;
      if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_tick !== e_tick) begin
        nerr++;
        $display("FAIL post_reset e=%0d: seg=%h an=%b tick=%b, want %h %b %b",
                 e, bus.seg, bus.an, bus.frame_tick, e_seg, e_an, e_tick);
      end
      if (e == 3) begin
        nchk++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'hFC) begin
          nerr++; $display("FAIL post_reset_digit0: an=%b seg=%h, want 1110 fc", bus.an, bus.seg);
        end
      end
      if (e == FR + RD) begin
        nchk++;
        if (bus.seg !== 8'hFC) begin
          nerr++; $display("FAIL post_reset_pending_cleared: seg=%h, want fc", bus.seg);
        end
      end
    end
  endtask

  initial begin
    bus.value = '0; bus.dp_mask = '0; bus.load = 1'b0;
    bus.enable = 1'b1; bus.lz_suppress = 1'b0;
    test_reset();
    test_load_midframe();
    test_back_to_back();
    test_lz_suppress();
    test_nonbcd();
    test_random();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
